// File: rtl/wb_cp0_regs_if.sv
// Writeback-stage CP0 write path: the registered mtc0 write leaving writeback.
// The master drives the write; the CP0 register bank is the slave.
interface wb_cp0_regs_if;
    logic        wb_cp0_reg_we;
    logic [4:0]  wb_cp0_reg_write_addr;
    logic [31:0] wb_cp0_reg_data;

    modport master (
        output wb_cp0_reg_we,
        output wb_cp0_reg_write_addr,
        output wb_cp0_reg_data
    );

    modport slave (
        input wb_cp0_reg_we,
        input wb_cp0_reg_write_addr,
        input wb_cp0_reg_data
    );
endinterface

// File: rtl/wb_cp0_regs.sv
// CP0 register bank: commits writeback mtc0 writes, serves bypassed mfc0 reads,
// records exceptions/ERET and, with CP0_TIMER_EN defined, runs the Count/Compare timer.
module wb_cp0_regs #(
    parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic                clk,
    input  logic                rst,
    wb_cp0_regs_if.slave        wb,
    input  logic [4:0]          raddr_i,
    output logic [31:0]         rdata_o,
    input  logic [5:0]          int_i,
    input  logic                exc_valid_i,
    input  logic [4:0]          exc_code_i,
    input  logic                exc_eret_i,
    input  logic [31:0]         exc_pc_i,
    input  logic                exc_in_delayslot_i,
    input  logic [31:0]         exc_badaddr_i,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o,
    output logic                timer_int_o
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;
    localparam logic [4:0] ADDR_CONFIG   = 5'd16;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    logic [31:0] badvaddr_q, status_q, cause_q, epc_q;
    logic [31:0] badvaddr_d, status_d, cause_d, epc_d;
    logic [31:0] status_pw, cause_pw, epc_pw;
    logic [31:0] count_q, compare_q, count_pw, compare_pw;
    logic        timer_q;
    logic        wr_status, wr_cause, wr_epc;

    assign wr_status = wb.wb_cp0_reg_we && (wb.wb_cp0_reg_write_addr == ADDR_STATUS);
    assign wr_cause  = wb.wb_cp0_reg_we && (wb.wb_cp0_reg_write_addr == ADDR_CAUSE);
    assign wr_epc    = wb.wb_cp0_reg_we && (wb.wb_cp0_reg_write_addr == ADDR_EPC);

    // "_pw" = register contents with this cycle's writeback write merged in.
    // They feed both the read bypass and the exception update, which layers on top.
    assign status_pw = wr_status ? ((status_q & ~STATUS_WMASK) | (wb.wb_cp0_reg_data & STATUS_WMASK) | STATUS_BEV)
                                 : status_q;
    assign cause_pw  = wr_cause  ? ((cause_q & ~CAUSE_WMASK) | (wb.wb_cp0_reg_data & CAUSE_WMASK))
                                 : cause_q;
    assign epc_pw    = wr_epc    ? wb.wb_cp0_reg_data : epc_q;

`ifdef CP0_TIMER_EN
    logic wr_count, wr_compare, phase_q;

    assign wr_count   = wb.wb_cp0_reg_we && (wb.wb_cp0_reg_write_addr == ADDR_COUNT);
    assign wr_compare = wb.wb_cp0_reg_we && (wb.wb_cp0_reg_write_addr == ADDR_COMPARE);
    assign count_pw   = wr_count   ? wb.wb_cp0_reg_data : count_q;
    assign compare_pw = wr_compare ? wb.wb_cp0_reg_data : compare_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            phase_q   <= 1'b0;
            timer_q   <= 1'b0;
        end else begin
            // A Count write overrides any increment and restarts the tick phase.
            if (wr_count) begin
                count_q <= wb.wb_cp0_reg_data;
                phase_q <= 1'b0;
            end else begin
                phase_q <= ~phase_q;
                if (phase_q) count_q <= count_q + 32'd1;
            end
            if (wr_compare) compare_q <= wb.wb_cp0_reg_data;
            if (wr_compare)
                timer_q <= 1'b0;
            else if ((compare_q != '0) && (count_q == compare_q))
                timer_q <= 1'b1;
        end
    end
`else
    assign count_q    = '0;
    assign compare_q  = '0;
    assign count_pw   = '0;
    assign compare_pw = '0;
    assign timer_q    = 1'b0;
`endif

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            ADDR_BADVADDR: rdata_o = badvaddr_q;
            ADDR_COUNT:    rdata_o = count_pw;
            ADDR_COMPARE:  rdata_o = compare_pw;
            ADDR_STATUS:   rdata_o = status_pw;
            ADDR_CAUSE:    rdata_o = cause_pw;
            ADDR_EPC:      rdata_o = epc_pw;
            ADDR_PRID:     rdata_o = PRID_VALUE;
            ADDR_CONFIG:   rdata_o = CONFIG_VALUE;
            default:       rdata_o = '0;
        endcase
    end

    always_comb begin
        status_d   = status_pw;
        cause_d    = cause_pw;
        epc_d      = epc_pw;
        badvaddr_d = badvaddr_q;
        cause_d[15:10] = {int_i[5] | timer_q, int_i[4:0]};
        // EPC/BD are only captured when not already in exception level,
        // judged after the older mtc0 has taken effect.
        if (exc_valid_i) begin
            if (!status_pw[1]) begin
                epc_d       = exc_in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                cause_d[31] = exc_in_delayslot_i;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code_i;
            if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5))
                badvaddr_d = exc_badaddr_i;
        end else if (exc_eret_i) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_BEV;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_q;

endmodule

// File: tb/tb_wb_cp0_regs.sv
// Randomized bench for wb_cp0_regs against a register-array reference model;
// follows CP0_TIMER_EN the same way the design does.
module tb_wb_cp0_regs;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif
  localparam logic [31:0] PRID   = 32'h0000_4220;
  localparam logic [31:0] CONFIG = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic        exc_valid_i, exc_eret_i, exc_in_delayslot_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i, exc_badaddr_i;
  logic [31:0] status_o, cause_o, epc_o;
  logic        timer_int_o;

  wb_cp0_regs_if wbif ();

  wb_cp0_regs dut (
    .clk                (clk),
    .rst                (rst),
    .wb                 (wbif),
    .raddr_i            (raddr_i),
    .rdata_o            (rdata_o),
    .int_i              (int_i),
    .exc_valid_i        (exc_valid_i),
    .exc_code_i         (exc_code_i),
    .exc_eret_i         (exc_eret_i),
    .exc_pc_i           (exc_pc_i),
    .exc_in_delayslot_i (exc_in_delayslot_i),
    .exc_badaddr_i      (exc_badaddr_i),
    .status_o           (status_o),
    .cause_o            (cause_o),
    .epc_o              (epc_o),
    .timer_int_o        (timer_int_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: architectural registers by number, Count as base + elapsed/2
  logic [31:0] m_r [0:31];
  logic [31:0] m_cnt_base;
  int unsigned m_cnt_n;
  bit          m_timer;

  function automatic logic [31:0] m_count();
    return TIMER_EN ? (m_cnt_base + 32'(m_cnt_n / 2)) : 32'd0;
  endfunction

  function automatic logic [31:0] m_stored(input logic [4:0] a);
    case (a)
      5'd9:    return m_count();
      5'd15:   return PRID;
      5'd16:   return CONFIG;
      default: return m_r[a];
    endcase
  endfunction

  function automatic logic [31:0] wmask(input logic [4:0] a);
    case (a)
      5'd12:       return 32'h0000_FF03;
      5'd13:       return 32'h0000_0300;
      5'd14:       return 32'hFFFF_FFFF;
      5'd9, 5'd11: return TIMER_EN ? 32'hFFFF_FFFF : 32'h0;
      default:     return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] m;
    m = wmask(a);
    if (wbif.wb_cp0_reg_we && wbif.wb_cp0_reg_write_addr == a)
      return (m_stored(a) & ~m) | (wbif.wb_cp0_reg_data & m);
    return m_stored(a);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_r[i] = 32'h0;
    m_r[12]    = 32'h0040_0000;
    m_cnt_base = 32'h0;
    m_cnt_n    = 0;
    m_timer    = 1'b0;
  endtask

  task automatic m_step();
    logic [31:0] old_count, old_cmp, m;
    logic [4:0]  a;
    bit          old_timer;
    if (rst) begin
      m_reset();
      return;
    end
    old_count = m_count();
    old_cmp   = m_r[11];
    old_timer = m_timer;
    a = wbif.wb_cp0_reg_write_addr;
    m = wmask(a);
    if (wbif.wb_cp0_reg_we && a == 5'd9 && TIMER_EN) begin
      m_cnt_base = wbif.wb_cp0_reg_data;
      m_cnt_n    = 0;
    end else begin
      m_cnt_n++;
    end
    if (wbif.wb_cp0_reg_we && a != 5'd9 && m != 32'h0)
      m_r[a] = (m_r[a] & ~m) | (wbif.wb_cp0_reg_data & m);
    if (TIMER_EN) begin
      if (wbif.wb_cp0_reg_we && a == 5'd11) m_timer = 1'b0;
      else if (old_cmp != 0 && old_count == old_cmp) m_timer = 1'b1;
    end
    m_r[13][15:10] = {int_i[5] | old_timer, int_i[4:0]};
    if (exc_valid_i) begin
      if (!m_r[12][1]) begin
        m_r[14]     = exc_in_delayslot_i ? exc_pc_i - 32'd4 : exc_pc_i;
        m_r[13][31] = exc_in_delayslot_i;
      end
      m_r[12][1]    = 1'b1;
      m_r[13][6:2]  = exc_code_i;
      if (exc_code_i == 5'd4 || exc_code_i == 5'd5) m_r[8] = exc_badaddr_i;
    end else if (exc_eret_i) begin
      m_r[12][1] = 1'b0;
    end
  endtask

  // one cycle: check outputs mid-cycle, then advance model on the edge
  task automatic step();
    @(negedge clk);
    check("rdata", rdata_o, m_read(raddr_i));
    check("status", status_o, m_r[12]);
    check("cause", cause_o, m_r[13]);
    check("epc", epc_o, m_r[14]);
    check("timer", {31'b0, timer_int_o}, {31'b0, m_timer});
    @(posedge clk);
    m_step();
    #1;
  endtask

  // driver tasks
  task automatic idle_inputs();
    wbif.wb_cp0_reg_we         = 1'b0;
    wbif.wb_cp0_reg_write_addr = 5'd0;
    wbif.wb_cp0_reg_data       = 32'h0;
    int_i              = 6'h0;
    exc_valid_i        = 1'b0;
    exc_eret_i         = 1'b0;
    exc_code_i         = 5'd0;
    exc_pc_i           = 32'h0;
    exc_in_delayslot_i = 1'b0;
    exc_badaddr_i      = 32'h0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle_inputs();
    wbif.wb_cp0_reg_we         = 1'b1;
    wbif.wb_cp0_reg_write_addr = a;
    wbif.wb_cp0_reg_data       = d;
    step();
    idle_inputs();
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                           input logic [31:0] bad);
    exc_valid_i        = 1'b1;
    exc_code_i         = code;
    exc_pc_i           = pc;
    exc_in_delayslot_i = ds;
    exc_badaddr_i      = bad;
  endtask

  initial begin
    logic [4:0] regs [0:7];
    bit         seen;
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

    idle_inputs();
    raddr_i = 5'd9;
    rst = 1'b1;
    @(posedge clk);
    m_reset();
    #1;
    rst = 1'b0;

    // reset values and Count after 10 idle cycles
    idle(10);
    check("count_after_reset", rdata_o, TIMER_EN ? 32'd5 : 32'd0);
    check("status_after_reset", status_o, 32'h0040_0000);
    check("cause_after_reset", cause_o, 32'h0);

    // masked Status write with same-cycle bypass
    idle_inputs();
    raddr_i = 5'd12;
    wbif.wb_cp0_reg_we         = 1'b1;
    wbif.wb_cp0_reg_write_addr = 5'd12;
    wbif.wb_cp0_reg_data       = 32'hFFFF_FFFF;
    #1;
    check("status_bypass", rdata_o, 32'h0040_FF03);
    step();
    idle_inputs();
    check("status_written", status_o, 32'h0040_FF03);
    mtc0(5'd12, 32'h0);

    // Count/Compare timer
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    raddr_i = 5'd9;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = timer_int_o;
    end
    if (TIMER_EN) begin
      check("timer_rise_seen", {31'b0, seen}, 32'd1);
      check("count_at_rise", rdata_o, 32'd20);
      step();
      check("cause_ip7", {31'b0, cause_o[15]}, 32'd1);
      mtc0(5'd11, 32'd100);
      check("timer_cleared", {31'b0, timer_int_o}, 32'd0);
    end else begin
      check("timer_stays_low", {31'b0, seen}, 32'd0);
      check("count_reads_zero", rdata_o, 32'd0);
    end

    // exceptions and ERET
    idle_inputs();
    raise_exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h0000_0003);
    raddr_i = 5'd8;
    step();
    idle_inputs();
    check("exc_epc", epc_o, 32'hBFC0_0100);
    check("exc_bd", {31'b0, cause_o[31]}, 32'd1);
    check("exc_code", {27'b0, cause_o[6:2]}, 32'd4);
    check("exc_exl", {31'b0, status_o[1]}, 32'd1);
    check("exc_badvaddr", rdata_o, 32'h0000_0003);
    raise_exc(5'd8, 32'h8000_0000, 1'b0, 32'h0);
    step();
    idle_inputs();
    check("exc2_epc_kept", epc_o, 32'hBFC0_0100);
    exc_eret_i = 1'b1;
    step();
    idle_inputs();
    check("eret_exl", {31'b0, status_o[1]}, 32'd0);

    // mtc0 clearing EXL together with an exception
    idle_inputs();
    wbif.wb_cp0_reg_we         = 1'b1;
    wbif.wb_cp0_reg_write_addr = 5'd12;
    wbif.wb_cp0_reg_data       = 32'h0;
    raise_exc(5'd8, 32'h8000_0040, 1'b0, 32'h0);
    step();
    idle_inputs();
    check("wb_exc_exl", {31'b0, status_o[1]}, 32'd1);
    check("wb_exc_code", {27'b0, cause_o[6:2]}, 32'd8);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      idle_inputs();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) begin
        wbif.wb_cp0_reg_we = 1'b1;
        wbif.wb_cp0_reg_write_addr = ($urandom_range(0, 9) < 8) ? regs[$urandom_range(0, 7)]
                                                                  : 5'($urandom_range(0, 31));
        wbif.wb_cp0_reg_data = $urandom();
        if (wbif.wb_cp0_reg_write_addr == 5'd11 && $urandom_range(0, 1) == 1)
          wbif.wb_cp0_reg_data = m_count() + 32'($urandom_range(0, 6));
      end
      raddr_i = ($urandom_range(0, 1) == 1) ? wbif.wb_cp0_reg_write_addr : regs[$urandom_range(0, 7)];
      int_i = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0)
        raise_exc(5'($urandom_range(0, 8)), $urandom(), 1'($urandom_range(0, 1)), $urandom());
      exc_eret_i = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0;

    // reset while a write and an exception are pending
    idle_inputs();
    wbif.wb_cp0_reg_we         = 1'b1;
    wbif.wb_cp0_reg_write_addr = 5'd14;
    wbif.wb_cp0_reg_data       = 32'h1234_5678;
    raise_exc(5'd4, 32'hBFC0_0200, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    raddr_i = 5'd8;
    #1;
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_timer", {31'b0, timer_int_o}, 32'd0);
    check("rst_badvaddr", rdata_o, 32'h0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_cp0_regs.md
Name: wb_cp0_regs

Overview:
- Coprocessor-0 register bank at the consuming end of the writeback-stage CP0 write path.
- Commits the registered mtc0 write (wb_cp0_reg_we/addr/data) and serves mfc0 reads to the execute stage, bypassing a same-cycle writeback write.
- Records exceptions and ERET from the memory stage.
- Runs the Count/Compare timer and produces the timer interrupt.

Parameters:
- PRID_VALUE, 32'h0000_4220, read-only value of PRId (reg 15).
- CONFIG_VALUE, 32'h0000_8000, read-only value of Config (reg 16).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- wb_cp0_reg_we  in  1  CP0 write enable from writeback stage
- wb_cp0_reg_write_addr  in  5  CP0 register number to write
- wb_cp0_reg_data  in  32  write data
- raddr_i  in  5  mfc0 read address (execute stage)
- rdata_o  out  32  read data, combinational, with bypass
- int_i  in  6  external hardware interrupt lines, level-sensitive
- exc_valid_i  in  1  memory-stage exception commit (not ERET)
- exc_code_i  in  5  ExcCode for the exception
- exc_eret_i  in  1  ERET commit
- exc_pc_i  in  32  PC of the faulting instruction
- exc_in_delayslot_i  in  1  faulting instruction is in a delay slot
- exc_badaddr_i  in  32  faulting address for AdEL/AdES
- status_o  out  32  current Status register
- cause_o  out  32  current Cause register
- epc_o  out  32  current EPC register
- timer_int_o  out  1  sticky timer interrupt

Behaviour:
- Reset:
  - Count, Compare, EPC, BadVAddr = 0.
  - Status = 32'h0040_0000 (BEV=1).
  - Cause = 0; timer_int_o = 0; tick phase = 0.
  - Outputs reflect these values in the cycle after the reset edge. Reset mid-operation discards any pending write or exception in that cycle.
- Registers implemented (by number): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16. Any other address reads 0 and ignores writes.
- Write masks:
  - Status: only IM[15:8], EXL[1], IE[0] are writable; BEV[22] is fixed at 1.
  - Cause: only IP[9:8] (software interrupts) is writable.
  - Count, Compare, EPC: fully writable.
  - BadVAddr, PRId, Config: read-only.
- Write latency: the write is visible in the register one cycle after wb_cp0_reg_we is sampled.
- Read bypass: rdata_o is combinational. If wb_cp0_reg_we=1 and the write address equals raddr_i, rdata_o returns the masked merge of the stored value and the write data, not the stale value.
- Cause.IP[15:10] is sampled every cycle:
  - IP[15:10] = int_i[5:0], except IP[15] = int_i[5] | timer_int_o.
- Count:
  - Increments by 1 every second cycle: the tick phase toggles each cycle and Count increments when the phase is 1.
  - Wraps from 32'hFFFF_FFFF to 0.
  - A Count write in the same cycle as an increment: the write wins and the phase resets to 0.
- Timer:
  - When Compare != 0 and Count == Compare, timer_int_o is set to 1 on the next edge.
  - It stays set until Compare is written; a Compare write clears it.
  - If set and clear occur in the same cycle, the clear wins.
- Exception (exc_valid_i=1):
  - If Status.EXL=0: EPC <= exc_in_delayslot_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD[31] <= exc_in_delayslot_i.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Status.EXL <= 1 and Cause.ExcCode[6:2] <= exc_code_i.
  - If exc_code_i is 4 (AdEL) or 5 (AdES): BadVAddr <= exc_badaddr_i.
- ERET (exc_eret_i=1): Status.EXL <= 0. If exc_valid_i and exc_eret_i are both 1, exc_valid_i takes priority.
- Writeback write and exception in the same cycle:
  - The writeback write is from the older instruction and is applied first.
  - The exception/ERET field updates then override the same fields (e.g. an mtc0 of EXL=0 together with an exception yields EXL=1).
  - The rdata_o bypass reflects only the writeback write.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count/Compare/timer behave exactly as described above.
- Undefined:
  - Count and Compare are not implemented: they read 0 and ignore writes.
  - timer_int_o is tied to 0.
  - Cause.IP[15] = int_i[5].

Test Plan:
- Reset, then idle 10 cycles -> Status=32'h0040_0000, Cause=0, Count=5 (with CP0_TIMER_EN).
- mtc0 Status 32'hFFFF_FFFF with raddr_i=12 in the same cycle -> rdata_o=32'h0040_FF03 that cycle; status_o=32'h0040_FF03 on the next cycle.
- Write Compare=20, Count=0 -> timer_int_o rises the cycle after Count reaches 20 and Cause[15]=1. Then write Compare=100 -> timer_int_o=0 on the next cycle.
- Exception with exc_code_i=4, pc=32'hBFC0_0104, delay slot=1, badaddr=32'h0000_0003 -> EPC=32'hBFC0_0100, Cause.BD=1, ExcCode=4, EXL=1, BadVAddr=32'h3. A second exception with pc=32'h8000_0000 -> EPC unchanged. Then ERET -> EXL=0.
- mtc0 Status EXL=0 in the same cycle as exc_valid_i (code 8) -> EXL=1, ExcCode=8.
- Assert rst while exc_valid_i=1 and wb_cp0_reg_we=1 -> all registers at reset values on the next cycle.
